ahb_resp_mux_dec: RTL and testbench
===================================

Name: ahb_resp_mux_dec

Overview:
Parametrised AHB-Lite slave-side interconnect block. It combines the address-phase decoder (per-slave HSEL), the data-phase response/read-data mux, and a built-in default slave. It sits between the master's address/control outputs and N slave response ports. It registers the slave selection only on accepted, valid transfers, and it returns a two-cycle ERROR response to transfers aimed at unmapped or disabled regions. It also counts those errors and captures the offending address.

Parameters:
NUM_SLAVES, 16, number of slave ports (1..2**REGION_BITS)
AW, 32, address width
DW, 32, data width
REGION_BITS, 4, top address bits used as slave index (HADDR_i[AW-1 -: REGION_BITS])
SLAVE_EN, all-ones (NUM_SLAVES bits), per-slave enable mask; a disabled slave is treated as unmapped
CNT_W, 8, error counter width

Ports:
HCLK  in  1  clock
HRST_N  in  1  reset, synchronous, active-low
HADDR_i  in  AW  master address (address phase)
HTRANS_i  in  2  master transfer type
HSEL_o  out  NUM_SLAVES  one-hot address-phase slave select
HREADY_i  in  NUM_SLAVES  per-slave HREADYOUT
HRDATA_i  in  NUM_SLAVES x DW  per-slave read data
HRESP_i  in  NUM_SLAVES  per-slave response (1=ERROR)
HRDATA_o  out  DW  muxed read data to master
HREADY_o  out  1  muxed ready, also fed back to all slaves as HREADY
HRESP_o  out  1  muxed response
err_cnt_o  out  CNT_W  saturating count of default-slave errors
err_addr_o  out  AW  address of most recent unmapped transfer

Behaviour:
- Clock is HCLK; reset HRST_N is synchronous, active-low. All state is updated only on the rising edge of HCLK.
- Reset values:
  - dp_valid=0, dp_sel=0, dp_default=0, FSM=DS_IDLE, err_cnt_o=0, err_addr_o=0.
  - Hence on the first cycle after reset: HREADY_o=1, HRESP_o=0, HRDATA_o=0.
- Address decode (combinational):
  - idx = region bits of HADDR_i.
  - A transfer is valid when HTRANS_i[1]=1 (NONSEQ or SEQ). IDLE and BUSY transfers are never valid.
  - mapped = (idx < NUM_SLAVES) && SLAVE_EN[idx].
  - HSEL_o[k] = valid && mapped && (idx==k). HSEL_o is zero for unmapped or non-valid transfers.
- Data-phase register, updated only when HREADY_o=1 (accept):
  - dp_valid <= valid.
  - dp_sel <= idx (truncated to the index width).
  - dp_default <= valid && !mapped.
  - When HREADY_o=0, all three hold their value.
- Output mux:
  - dp_valid=0: HREADY_o=1, HRESP_o=0, HRDATA_o=0.
  - dp_valid=1 and dp_default=0: HRDATA_o/HREADY_o/HRESP_o = HRDATA_i/HREADY_i/HRESP_i[dp_sel], passed through unmodified, including slave wait states and slave ERROR.
  - dp_default=1: outputs come from the default-slave FSM; HRDATA_o=0.
- Default-slave FSM, states DS_IDLE, DS_ERR1, DS_ERR2:
  - DS_IDLE: no drive. An accepted, valid, unmapped transfer moves to DS_ERR1.
  - DS_ERR1: HREADY_o=0, HRESP_o=1. Always moves to DS_ERR2.
  - DS_ERR2: HREADY_o=1, HRESP_o=1. The master may present a new transfer in this cycle:
    - new accepted, valid, unmapped transfer: DS_ERR1;
    - otherwise: DS_IDLE.
  - An IDLE/BUSY transfer to an unmapped address completes with OKAY in zero wait states and is not an error.
- Error logging:
  - On each transition into DS_ERR1: err_cnt_o increments, saturating at 2**CNT_W-1, and err_addr_o <= HADDR_i of the accepted transfer.
- Back-to-back transfers: a slave-to-slave switch takes effect on the cycle after acceptance, with no bubble. A slave wait state stalls dp_sel, so the next address phase is held.
- Reset asserted mid-transfer, including in DS_ERR1: the next edge forces all reset values; HREADY_o=1 and HRESP_o=0 the following cycle. The counter and captured address clear.
- NUM_SLAVES < 2**REGION_BITS: the unpopulated upper indices decode to the default slave.

Decomposition:
- Package ahb_pkg holds:
  - HTRANS encodings (IDLE=2'b00, BUSY=2'b01, NONSEQ=2'b10, SEQ=2'b11);
  - HRESP encodings (OKAY=0, ERROR=1);
  - ds_state_e enum;
  - a function for computing the index width.
- Sub-module ahb_default_slave contains the FSM plus error counter/address capture. Its inputs are accept, err_req and HADDR_i; its outputs are ds_ready, ds_resp, err_cnt and err_addr. The top level contains the decode, the data-phase register and the mux.

Test Plan:
- NONSEQ to 0x2000_0000, slave 2 HREADY_i=1, HRDATA_i[2]=0xDEADBEEF → HSEL_o=0x0004 in the address cycle; next cycle HRDATA_o=0xDEADBEEF, HREADY_o=1, HRESP_o=0.
- Slave 5 access with HREADY_i[5] low for 3 cycles → HREADY_o low for exactly 3 cycles; a pending NONSEQ to slave 6 is not latched until the 4th cycle.
- NUM_SLAVES=8, NONSEQ to 0xA000_0010 → cycle+1: HREADY_o=0, HRESP_o=1; cycle+2: HREADY_o=1, HRESP_o=1; then err_cnt_o=1, err_addr_o=0xA000_0010.
- IDLE transfer to 0xF000_0000 → HSEL_o=0, next cycle HREADY_o=1, HRESP_o=0, err_cnt_o unchanged.
- CNT_W=2, 5 consecutive unmapped NONSEQs (each issued in DS_ERR2) → sequence ERR1/ERR2 repeated 5 times with no idle gap; err_cnt_o saturates at 3.
- HRST_N low during DS_ERR1 → next cycle HREADY_o=1, HRESP_o=0, err_cnt_o=0, err_addr_o=0.

Source files
------------

// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB-Lite encodings and helpers for the response mux/decoder
package ahb_pkg;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;
  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;
  typedef enum logic [1:0] {DS_IDLE, DS_ERR1, DS_ERR2} ds_state_e;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/ahb_default_slave.sv
// ahb_default_slave: two-cycle ERROR responder with saturating error count and address capture
module ahb_default_slave
  import ahb_pkg::*;
#(
  parameter int AW    = 32,
  parameter int CNT_W = 8
)(
  input  logic             HCLK,
  input  logic             HRST_N,
  input  logic             accept,
  input  logic             err_req,
  input  logic [AW-1:0]    HADDR_i,
  output logic             ds_ready,
  output logic             ds_resp,
  output logic [CNT_W-1:0] err_cnt,
  output logic [AW-1:0]    err_addr
);
  ds_state_e state, state_nxt;
  logic start;
  always_comb begin
    start     = accept && err_req && state != DS_ERR1;
    state_nxt = start ? DS_ERR1 : (state == DS_ERR1) ? DS_ERR2 : DS_IDLE;
    ds_ready  = state != DS_ERR1;
    ds_resp   = (state == DS_IDLE) ? HRESP_OKAY : HRESP_ERROR;
  end
  always_ff @(posedge HCLK) begin
    if (!HRST_N) begin
      state    <= DS_IDLE;
      err_cnt  <= '0;
      err_addr <= '0;
    end else begin
      state <= state_nxt;
      if (start) begin
        err_cnt  <= (err_cnt == '1) ? err_cnt : err_cnt + 1'b1;
        err_addr <= HADDR_i;
      end
    end
  end
endmodule

// File: rtl/ahb_resp_mux_dec.sv
// ahb_resp_mux_dec: AHB-Lite address decoder, data-phase response mux and default slave
module ahb_resp_mux_dec
  import ahb_pkg::*;
#(
  parameter int                    NUM_SLAVES  = 16,
  parameter int                    AW          = 32,
  parameter int                    DW          = 32,
  parameter int                    REGION_BITS = 4,
  parameter logic [NUM_SLAVES-1:0] SLAVE_EN    = '1,
  parameter int                    CNT_W       = 8
)(
  input  logic                           HCLK,
  input  logic                           HRST_N,
  input  logic [AW-1:0]                  HADDR_i,
  input  logic [1:0]                     HTRANS_i,
  output logic [NUM_SLAVES-1:0]          HSEL_o,
  input  logic [NUM_SLAVES-1:0]          HREADY_i,
  input  logic [NUM_SLAVES-1:0][DW-1:0]  HRDATA_i,
  input  logic [NUM_SLAVES-1:0]          HRESP_i,
  output logic [DW-1:0]                  HRDATA_o,
  output logic                           HREADY_o,
  output logic                           HRESP_o,
  output logic [CNT_W-1:0]               err_cnt_o,
  output logic [AW-1:0]                  err_addr_o
);
  localparam int IW = idx_w(NUM_SLAVES);
  localparam int NR = 2 ** REGION_BITS;
  logic [REGION_BITS-1:0] idx;
  logic [NR-1:0] map_tab;
  logic valid, mapped, err_req, dp_valid, dp_default, ds_ready, ds_resp;
  logic [IW-1:0] dp_sel;
  // unpopulated regions above NUM_SLAVES fall through to the default slave
  for (genvar g = 0; g < NR; g++) begin : g_map
    if (g < NUM_SLAVES) begin : g_on
      assign map_tab[g] = SLAVE_EN[g];
    end else begin : g_off
      assign map_tab[g] = 1'b0;
    end
  end
  always_comb begin
    idx      = HADDR_i[AW-1 -: REGION_BITS];
    valid    = HTRANS_i == HTRANS_NONSEQ || HTRANS_i == HTRANS_SEQ;
    mapped   = map_tab[idx];
    err_req  = valid && !mapped;
    HSEL_o   = (valid && mapped) ? NUM_SLAVES'(1) << idx : '0;
    HRDATA_o = (dp_valid && !dp_default) ? HRDATA_i[dp_sel] : '0;
    HREADY_o = !dp_valid ? 1'b1 : dp_default ? ds_ready : HREADY_i[dp_sel];
    HRESP_o  = !dp_valid ? HRESP_OKAY : dp_default ? ds_resp : HRESP_i[dp_sel];
  end
  always_ff @(posedge HCLK) begin
    if (!HRST_N) begin
      dp_valid   <= 1'b0;
      dp_sel     <= '0;
      dp_default <= 1'b0;
    end else if (HREADY_o) begin
      dp_valid   <= valid;
      dp_sel     <= idx[IW-1:0];
      dp_default <= err_req;
    end
  end
  ahb_default_slave #(.AW(AW), .CNT_W(CNT_W)) u_ds (
    .HCLK     (HCLK),
    .HRST_N   (HRST_N),
    .accept   (HREADY_o),
    .err_req  (err_req),
    .HADDR_i  (HADDR_i),
    .ds_ready (ds_ready),
    .ds_resp  (ds_resp),
    .err_cnt  (err_cnt_o),
    .err_addr (err_addr_o)
  );
endmodule

// File: tb/tb_ahb_resp_mux_dec.sv
// tb_ahb_resp_mux_dec: vector table, corner sequences and randomized traffic against a transaction model
module tb_ahb_resp_mux_dec;
  localparam int NS = 8, AW = 32, DW = 32, RB = 4, CW = 2;
  localparam logic [NS-1:0] EN = 8'hF7;
  localparam int CMAX = (1 << CW) - 1;
  logic HCLK = 1'b0, HRST_N = 1'b0;
  logic [AW-1:0] haddr;
  logic [1:0] htrans;
  logic [NS-1:0] hsel, hready_in, hresp_in;
  logic [NS-1:0][DW-1:0] hrdata_in;
  logic [DW-1:0] hrdata;
  logic hready, hresp;
  logic [CW-1:0] err_cnt;
  logic [AW-1:0] err_addr;
  int n_cmp = 0, n_bad = 0;
  int m_kind, m_sel, m_cnt;
  logic [AW-1:0] m_eaddr;
  logic e_rdy, e_rsp;
  logic [DW-1:0] e_dat;
  logic [15:0] en16 = 16'(EN);
  typedef struct {
    logic [AW-1:0] addr;
    logic [1:0] trans;
    logic [NS-1:0] rdy, rsp, hsel;
    logic ready, resp;
    logic [DW-1:0] data;
  } vec_t;
  vec_t tbl[19];

  ahb_resp_mux_dec #(.NUM_SLAVES(NS), .AW(AW), .DW(DW), .REGION_BITS(RB), .SLAVE_EN(EN), .CNT_W(CW)) dut (
    .HCLK(HCLK), .HRST_N(HRST_N), .HADDR_i(haddr), .HTRANS_i(htrans), .HSEL_o(hsel),
    .HREADY_i(hready_in), .HRDATA_i(hrdata_in), .HRESP_i(hresp_in), .HRDATA_o(hrdata),
    .HREADY_o(hready), .HRESP_o(hresp), .err_cnt_o(err_cnt), .err_addr_o(err_addr));

  always #5 HCLK = ~HCLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  function automatic int region(input logic [AW-1:0] a);
    return int'(a[AW-1 -: RB]);
  endfunction

  function automatic bit is_mapped(input logic [AW-1:0] a);
    return region(a) < NS && en16[region(a)];
  endfunction

  function automatic logic [NS-1:0] exp_hsel(input logic [AW-1:0] a, input logic [1:0] t);
    return (t[1] && is_mapped(a)) ? NS'(1) << region(a) : '0;
  endfunction

  // m_kind: 0 no data phase, 1 slave data phase, 2 first error cycle, 3 second error cycle
  task automatic model_check();
    case (m_kind)
      1: begin e_rdy = hready_in[m_sel]; e_rsp = hresp_in[m_sel]; e_dat = hrdata_in[m_sel]; end
      2: begin e_rdy = 1'b0; e_rsp = 1'b1; e_dat = '0; end
      3: begin e_rdy = 1'b1; e_rsp = 1'b1; e_dat = '0; end
      default: begin e_rdy = 1'b1; e_rsp = 1'b0; e_dat = '0; end
    endcase
    chk("hsel", 64'(hsel), 64'(exp_hsel(haddr, htrans)));
    chk("hready", 64'(hready), 64'(e_rdy));
    chk("hresp", 64'(hresp), 64'(e_rsp));
    chk("hrdata", 64'(hrdata), 64'(e_dat));
    chk("err_cnt", 64'(err_cnt), 64'(m_cnt));
    chk("err_addr", 64'(err_addr), 64'(m_eaddr));
  endtask

  task automatic model_step();
    if (!HRST_N) begin
      m_kind = 0; m_sel = 0; m_cnt = 0; m_eaddr = '0;
    end else if (m_kind == 2) m_kind = 3;
    else if (e_rdy) begin
      if (!htrans[1]) m_kind = 0;
      else if (is_mapped(haddr)) begin m_kind = 1; m_sel = region(haddr); end
      else begin
        m_kind = 2;
        m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
        m_eaddr = haddr;
      end
    end
  endtask

  task automatic apply(input logic [AW-1:0] a, input logic [1:0] t);
    haddr = a;
    htrans = t;
    @(negedge HCLK);
    model_check();
  endtask

  task automatic adv();
    model_step();
    @(posedge HCLK);
    #1;
  endtask

  initial begin
    haddr = '0; htrans = 2'b00; hready_in = '1; hresp_in = '0;
    for (int k = 0; k < NS; k++) hrdata_in[k] = 32'h1111_1111 * k;
    hrdata_in[2] = 32'hDEAD_BEEF;
    m_kind = 0; m_sel = 0; m_cnt = 0; m_eaddr = '0; e_rdy = 1'b1;
    tbl[0]  = '{32'h2000_0000, 2'b10, 8'hFF, 8'h00, 8'h04, 1'b1, 1'b0, 32'h0};
    tbl[1]  = '{32'h0000_0000, 2'b00, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b0, 32'hDEAD_BEEF};
    tbl[2]  = '{32'h5000_0000, 2'b10, 8'hFF, 8'h00, 8'h20, 1'b1, 1'b0, 32'h0};
    tbl[3]  = '{32'h6000_0000, 2'b10, 8'hDF, 8'h00, 8'h40, 1'b0, 1'b0, 32'h5555_5555};
    tbl[4]  = '{32'h6000_0000, 2'b10, 8'hDF, 8'h00, 8'h40, 1'b0, 1'b0, 32'h5555_5555};
    tbl[5]  = '{32'h6000_0000, 2'b10, 8'hDF, 8'h00, 8'h40, 1'b0, 1'b0, 32'h5555_5555};
    tbl[6]  = '{32'h6000_0000, 2'b10, 8'hFF, 8'h00, 8'h40, 1'b1, 1'b0, 32'h5555_5555};
    tbl[7]  = '{32'h0000_0000, 2'b00, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b0, 32'h6666_6666};
    tbl[8]  = '{32'hA000_0010, 2'b10, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b0, 32'h0};
    tbl[9]  = '{32'h0000_0000, 2'b00, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b1, 32'h0};
    tbl[10] = '{32'hF000_0000, 2'b00, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b1, 32'h0};
    tbl[11] = '{32'h3000_0000, 2'b11, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b0, 32'h0};
    tbl[12] = '{32'h0000_0000, 2'b00, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b1, 32'h0};
    tbl[13] = '{32'h9000_0000, 2'b10, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b1, 32'h0};
    tbl[14] = '{32'h0000_0000, 2'b00, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b1, 32'h0};
    tbl[15] = '{32'h0000_0000, 2'b00, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b1, 32'h0};
    tbl[16] = '{32'h1000_0000, 2'b01, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b0, 32'h0};
    tbl[17] = '{32'h7000_0004, 2'b11, 8'hFF, 8'h80, 8'h80, 1'b1, 1'b0, 32'h0};
    tbl[18] = '{32'h0000_0000, 2'b00, 8'hFF, 8'h80, 8'h00, 1'b1, 1'b1, 32'h7777_7777};
    @(posedge HCLK);
    #1;
    HRST_N = 1'b1;
    for (int i = 0; i < 19; i++) begin
      hready_in = tbl[i].rdy;
      hresp_in = tbl[i].rsp;
      apply(tbl[i].addr, tbl[i].trans);
      chk($sformatf("tbl%0d_hsel", i), 64'(hsel), 64'(tbl[i].hsel));
      chk($sformatf("tbl%0d_hready", i), 64'(hready), 64'(tbl[i].ready));
      chk($sformatf("tbl%0d_hresp", i), 64'(hresp), 64'(tbl[i].resp));
      chk($sformatf("tbl%0d_hrdata", i), 64'(hrdata), 64'(tbl[i].data));
      if (i == 9) begin
        chk("tbl_err_cnt_first", 64'(err_cnt), 64'd1);
        chk("tbl_err_addr_first", 64'(err_addr), 64'hA000_0010);
      end
      adv();
    end
    hresp_in = '0;
    chk("tbl_err_cnt_end", 64'(err_cnt), 64'd3);
    chk("tbl_err_addr_end", 64'(err_addr), 64'h9000_0000);
    // back-to-back unmapped NONSEQs, each re-issued in the second error cycle
    HRST_N = 1'b0;
    apply('0, 2'b00);
    adv();
    HRST_N = 1'b1;
    for (int i = 0; i <= 10; i++) begin
      apply(32'hC000_0000 | 32'(i), (i < 10) ? 2'b10 : 2'b00);
      chk($sformatf("sat%0d_hready", i), 64'(hready), (i % 2 == 1) ? 64'd0 : 64'd1);
      chk($sformatf("sat%0d_hresp", i), 64'(hresp), (i == 0) ? 64'd0 : 64'd1);
      adv();
    end
    chk("sat_err_cnt", 64'(err_cnt), 64'd3);
    chk("sat_err_addr", 64'(err_addr), 64'hC000_0008);
    // reset landing in the first error cycle
    apply(32'hB000_0000, 2'b10);
    adv();
    HRST_N = 1'b0;
    apply('0, 2'b00);
    chk("rst_err1_hready", 64'(hready), 64'd0);
    adv();
    HRST_N = 1'b1;
    apply('0, 2'b00);
    chk("rst_after_hready", 64'(hready), 64'd1);
    chk("rst_after_hresp", 64'(hresp), 64'd0);
    chk("rst_after_cnt", 64'(err_cnt), 64'd0);
    chk("rst_after_addr", 64'(err_addr), 64'd0);
    adv();
    for (int i = 0; i < 3000; i++) begin
      HRST_N = ($urandom_range(0, 199) != 0);
      hready_in = NS'($urandom | $urandom);
      hresp_in = NS'($urandom & $urandom & $urandom);
      for (int k = 0; k < NS; k++) hrdata_in[k] = $urandom;
      apply({$urandom} , 2'($urandom_range(0, 3)));
      adv();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
